// File: rtl/maze_pkg.sv
// Shared maze definitions: the four move codes and the path reader state encoding.
package maze_pkg;

  localparam logic [1:0] UP    = 2'b00;
  localparam logic [1:0] RIGHT = 2'b01;
  localparam logic [1:0] DOWN  = 2'b10;
  localparam logic [1:0] LEFT  = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LOAD    = 3'd2,
    PRESENT = 3'd3,
    FINISH  = 3'd4
  } reader_state_e;

endpackage

// File: rtl/path_addr_counter.sv
// Loadable up/down address counter that drives the move memory read address.
module path_addr_counter #(
  parameter int ADR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [ADR_W-1:0] load_val,
  input  logic             step,
  input  logic             down,
  output logic [ADR_W-1:0] addr
);

  logic [ADR_W-1:0] addr_r;

  // Address register: load has priority over stepping.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r <= {ADR_W{1'b0}};
    end else if (load) begin
      addr_r <= load_val;
    end else if (step) begin
      addr_r <= down ? (addr_r - ADR_W'(1'b1)) : (addr_r + ADR_W'(1'b1));
    end else begin
      addr_r <= addr_r;
    end
  end

  assign addr = addr_r;

endmodule

// File: rtl/path_reader.sv
// Replays a stored path from a synchronous-read move memory, one move per valid/ready transfer.
// Defining PATH_READER_REVERSE_EN adds a 'reverse' input that replays the path last-in first-out.
module path_reader
  import maze_pkg::*;
#(
  parameter int N      = 2,
  parameter int size   = 16,
  localparam int ADR_W = $clog2(size)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADR_W:0]   depth,
`ifdef PATH_READER_REVERSE_EN
  input  logic             reverse,
`endif
  output logic [ADR_W-1:0] mem_raddr,
  input  logic [N-1:0]     mem_rdata,
  output logic [N-1:0]     move_out,
  output logic             move_valid,
  input  logic             move_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [ADR_W:0] SIZE_V = (ADR_W+1)'(size);

  reader_state_e    state_r, state_s;
  logic [ADR_W:0]   remaining_r, clamp_s;
  logic [N-1:0]     move_out_r;
  logic             move_valid_r, busy_r, done_r, down_r;
  logic             rev_s, accept_s, load_s, xfer_s, step_s;
  logic [ADR_W-1:0] load_val_s;

`ifdef PATH_READER_REVERSE_EN
  assign rev_s = reverse;
`else
  assign rev_s = 1'b0;
`endif

  // Start qualification, transfer detect and first-address selection.
  always_comb begin
    clamp_s  = (depth > SIZE_V) ? SIZE_V : depth;
    accept_s = (state_r == IDLE) && start;
    load_s   = accept_s && (depth != {(ADR_W+1){1'b0}});
    xfer_s   = (state_r == PRESENT) && move_valid_r && move_ready;
    // No step after the last transfer keeps the address inside the memory.
    step_s   = xfer_s && (remaining_r != (ADR_W+1)'(1'b1));
    if (rev_s) begin
      load_val_s = clamp_s[ADR_W-1:0] - ADR_W'(1'b1);
    end else begin
      load_val_s = {ADR_W{1'b0}};
    end
  end

  path_addr_counter #(.ADR_W(ADR_W)) u_addr (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (load_val_s),
    .step     (step_s),
    .down     (down_r),
    .addr     (mem_raddr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (depth == {(ADR_W+1){1'b0}}) state_s = FINISH;
          else                            state_s = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH:   state_s = LOAD;
      LOAD:    state_s = PRESENT;
      PRESENT: begin
        if (xfer_s) begin
          if (remaining_r == (ADR_W+1)'(1'b1)) state_s = FINISH;
          else                                 state_s = FETCH;
        end else begin
          state_s = PRESENT;
        end
      end
      FINISH:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Registered outputs and replay bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_r  <= {(ADR_W+1){1'b0}};
      move_out_r   <= {N{1'b0}};
      move_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      down_r       <= 1'b0;
    end else begin
      done_r <= (state_r == FINISH);
      if (load_s)                 busy_r <= 1'b1;
      else if (state_r == FINISH) busy_r <= 1'b0;
      else                        busy_r <= busy_r;
      if (load_s)      remaining_r <= clamp_s;
      else if (xfer_s) remaining_r <= remaining_r - (ADR_W+1)'(1'b1);
      else             remaining_r <= remaining_r;
      if (accept_s) down_r <= rev_s;
      else          down_r <= down_r;
      if (state_r == LOAD) begin
        move_out_r   <= mem_rdata;
        move_valid_r <= 1'b1;
      end else if (xfer_s) begin
        move_out_r   <= move_out_r;
        move_valid_r <= 1'b0;
      end else begin
        move_out_r   <= move_out_r;
        move_valid_r <= move_valid_r;
      end
    end
  end

  assign move_out   = move_out_r;
  assign move_valid = move_valid_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_path_reader.sv
// Directed self-checking bench for path_reader with a one-cycle-latency memory model.
module tb_path_reader;
  import maze_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, move_ready, move_valid, busy, done;
  logic [4:0] depth;
  logic [3:0] mem_raddr;
  logic [1:0] mem_rdata, move_out;
`ifdef PATH_READER_REVERSE_EN
  logic       reverse = 1'b0;
`endif
  logic [1:0] mem [16];

  int checks = 0;
  int errors = 0;
  logic [1:0] got_q[$];
  logic [1:0] hold_q[$];
  int addr_q[$];
  int xfer_q[$];
  int done_cyc, max_addr;

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_raddr];

  path_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .depth      (depth),
`ifdef PATH_READER_REVERSE_EN
    .reverse    (reverse),
`endif
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .move_out   (move_out),
    .move_valid (move_valid),
    .move_ready (move_ready),
    .busy       (busy),
    .done       (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 = start driven; cycle k = sample point 1 ns after the k-th edge.
  task automatic replay(input logic [4:0] d, input int stall, input int extra_start);
    int cyc;
    int stall_left;
    got_q.delete(); hold_q.delete(); addr_q.delete(); xfer_q.delete();
    done_cyc = -1; max_addr = 0; stall_left = stall;
    depth = d; start = 1'b1; move_ready = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (done_cyc < 0 && cyc < 200) begin
      if (int'(mem_raddr) > max_addr) max_addr = int'(mem_raddr);
      if (done === 1'b1) done_cyc = cyc;
      start = (cyc == extra_start);
      if (move_valid === 1'b1 && stall_left > 0) begin
        move_ready = 1'b0;
        hold_q.push_back(move_out);
        stall_left--;
      end else begin
        move_ready = 1'b1;
        if (move_valid === 1'b1) begin
          got_q.push_back(move_out);
          addr_q.push_back(int'(mem_raddr));
          xfer_q.push_back(cyc);
        end
      end
      if (done_cyc < 0) begin
        step();
        cyc++;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (mem_raddr !== 4'd0)  begin errors++; $display("FAIL reset_raddr got=%0d exp=0", mem_raddr); end
    checks++; if (move_out !== 2'b00)  begin errors++; $display("FAIL reset_move_out got=%0b exp=00", move_out); end
    checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", move_valid); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
  endtask

  task automatic test_basic();
    logic [1:0] exp_m [4];
    logic [1:0] a;
    exp_m = '{RIGHT, RIGHT, DOWN, LEFT};
    replay(5'd4, 0, -1);
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL basic_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      a = (i < got_q.size()) ? got_q[i] : 2'bxx;
      checks++; if (a !== exp_m[i]) begin errors++; $display("FAIL basic_move%0d got=%0b exp=%0b", i, a, exp_m[i]); end
      a = (i < addr_q.size()) ? 2'(addr_q[i]) : 2'bxx;
      checks++; if (a !== 2'(i)) begin errors++; $display("FAIL basic_addr%0d got=%0d exp=%0d", i, a, i); end
    end
    checks++; if (xfer_q.size() < 4 || xfer_q[0] != 3 || xfer_q[3] - xfer_q[2] != 3)
      begin errors++; $display("FAIL basic_throughput xfer_cycles=%p exp=3,6,9,12", xfer_q); end
    checks++; if (done_cyc !== 14) begin errors++; $display("FAIL basic_done_cycle got=%0d exp=14", done_cyc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got=%0b exp=0", busy); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got=%0b exp=0", done); end
  endtask

  task automatic test_zero_depth();
    depth = 5'd0; start = 1'b1; move_ready = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b0 || move_valid !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL zero_c1 busy/valid/done got=%0b%0b%0b exp=000", busy, move_valid, done); end
    step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got=%0b exp=1", done); end
    checks++; if (busy !== 1'b0 || move_valid !== 1'b0)
      begin errors++; $display("FAIL zero_c2 busy/valid got=%0b%0b exp=00", busy, move_valid); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width got=%0b exp=0", done); end
  endtask

  task automatic test_stall();
    logic [1:0] exp_m [3];
    logic [1:0] a;
    exp_m = '{RIGHT, RIGHT, DOWN};
    replay(5'd3, 5, -1);
    checks++; if (hold_q.size() !== 5) begin errors++; $display("FAIL stall_len got=%0d exp=5", hold_q.size()); end
    for (int i = 0; i < hold_q.size(); i++) begin
      checks++; if (hold_q[i] !== RIGHT) begin errors++; $display("FAIL stall_hold%0d got=%0b exp=01", i, hold_q[i]); end
    end
    checks++; if (xfer_q.size() < 1 || xfer_q[0] != 8)
      begin errors++; $display("FAIL stall_first_xfer cycles=%p exp_first=8", xfer_q); end
    for (int i = 0; i < 3; i++) begin
      a = (i < got_q.size()) ? got_q[i] : 2'bxx;
      checks++; if (a !== exp_m[i]) begin errors++; $display("FAIL stall_move%0d got=%0b exp=%0b", i, a, exp_m[i]); end
    end
    checks++; if (done_cyc !== 16) begin errors++; $display("FAIL stall_done_cycle got=%0d exp=16", done_cyc); end
  endtask

  task automatic test_ignore_start();
    replay(5'd2, 0, 2);
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL ignore_count got=%0d exp=2", got_q.size()); end
    checks++; if (done_cyc !== 8) begin errors++; $display("FAIL ignore_done_cycle got=%0d exp=8", done_cyc); end
  endtask

  task automatic test_back_to_back();
    replay(5'd1, 0, -1);
    checks++; if (got_q.size() !== 1 || got_q[0] !== RIGHT)
      begin errors++; $display("FAIL b2b_moves got=%p exp=01", got_q); end
    checks++; if (done_cyc !== 5) begin errors++; $display("FAIL b2b_done_cycle got=%0d exp=5", done_cyc); end
  endtask

  task automatic test_clamp();
    int bad;
    replay(5'd20, 0, -1);
    checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL clamp_count got=%0d exp=16", got_q.size()); end
    checks++; if (max_addr !== 15) begin errors++; $display("FAIL clamp_max_addr got=%0d exp=15", max_addr); end
    bad = 0;
    for (int i = 0; i < got_q.size() && i < 16; i++) if (got_q[i] !== mem[i]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL clamp_moves wrong=%0d exp=0", bad); end
    checks++; if (done_cyc !== 50) begin errors++; $display("FAIL clamp_done_cycle got=%0d exp=50", done_cyc); end
  endtask

  task automatic test_mid_reset();
    int done_hits;
    int valid_hits;
    depth = 5'd4; start = 1'b1; move_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 7; i++) step();
    checks++; if (busy !== 1'b1 || move_out !== RIGHT)
      begin errors++; $display("FAIL midrst_pre busy/move got=%0b/%0b exp=1/01", busy, move_out); end
    rst = 1'b1;
    step();
    checks++; if ({mem_raddr, move_out, move_valid, busy, done} !== 9'd0)
      begin errors++; $display("FAIL midrst_outputs raddr=%0d move=%0b v=%0b b=%0b d=%0b exp=all0", mem_raddr, move_out, move_valid, busy, done); end
    rst = 1'b0;
    done_hits = 0; valid_hits = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) done_hits++;
      if (move_valid === 1'b1 || busy === 1'b1) valid_hits++;
      step();
    end
    checks++; if (done_hits !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", done_hits); end
    checks++; if (valid_hits !== 0) begin errors++; $display("FAIL midrst_idle got=%0d exp=0", valid_hits); end
  endtask

`ifdef PATH_READER_REVERSE_EN
  task automatic test_reverse();
    logic [1:0] exp_m [4];
    logic [1:0] a;
    exp_m = '{LEFT, DOWN, RIGHT, RIGHT};
    reverse = 1'b1;
    replay(5'd4, 0, -1);
    reverse = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = (i < got_q.size()) ? got_q[i] : 2'bxx;
      checks++; if (a !== exp_m[i]) begin errors++; $display("FAIL rev_move%0d got=%0b exp=%0b", i, a, exp_m[i]); end
      a = (i < addr_q.size()) ? 2'(addr_q[i]) : 2'bxx;
      checks++; if (a !== 2'(3 - i)) begin errors++; $display("FAIL rev_addr%0d got=%0d exp=%0d", i, a, 3 - i); end
    end
  endtask
`endif

  initial begin
    logic [3:0] iv;
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      mem[i] = iv[1:0] ^ 2'b10;
    end
    mem[0] = RIGHT; mem[1] = RIGHT; mem[2] = DOWN; mem[3] = LEFT;
    rst = 1'b1; start = 1'b0; depth = 5'd0; move_ready = 1'b0;
    step();
    step();
    test_reset();
    rst = 1'b0;
    step();
    test_basic();
    test_zero_depth();
    test_stall();
    test_ignore_start();
    test_back_to_back();
    test_clamp();
`ifdef PATH_READER_REVERSE_EN
    test_reverse();
`endif
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
